// File: rtl/nibbler_pkg.sv
// Shared definitions for the nibbler sequencer: opcodes, ALU selects,
// state encoding, the decoded-control bundle and the jump-condition helper.
package nibbler_pkg;

  // Opcodes (upper nibble of the first instruction byte)
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LIT   = 4'h1;
  localparam logic [3:0] OP_ADDI  = 4'h2;
  localparam logic [3:0] OP_CMPI  = 4'h3;
  localparam logic [3:0] OP_NANDI = 4'h4;
  localparam logic [3:0] OP_OUT   = 4'h5;
  localparam logic [3:0] OP_IN    = 4'h6;
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_JC    = 4'h9;
  localparam logic [3:0] OP_JNC   = 4'hA;
  localparam logic [3:0] OP_JZ    = 4'hB;
  localparam logic [3:0] OP_JNZ   = 4'hC;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // ALU select codes driven on alu_sel
  localparam logic [2:0] ALU_PASS_A = 3'd0;
  localparam logic [2:0] ALU_SUB    = 3'd1;
  localparam logic [2:0] ALU_PASS_B = 3'd2;
  localparam logic [2:0] ALU_ADD    = 3'd3;
  localparam logic [2:0] ALU_NAND   = 3'd4;

  // Sequencer state encoding
  localparam logic [1:0] ST_FETCH  = 2'd0;
  localparam logic [1:0] ST_FETCH2 = 2'd1;
  localparam logic [1:0] ST_EXEC   = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  // Control bundle produced by the decoder for one opcode
  typedef struct packed {
    logic [2:0] alu_sel;
    logic       b_sel;
    logic       acc_we;
    logic       out_we;
    logic       flag_we;
    logic       is_jump;
    logic       is_two_byte;
    logic       is_halt;
  } dec_t;

  // Branch condition for the jump opcodes, evaluated on the current flags
  function automatic logic jump_taken(input logic [3:0] op,
                                      input logic       c,
                                      input logic       z);
    logic taken;
    case (op)
      OP_JMP:  taken = 1'b1;
      OP_JC:   taken = c;
      OP_JNC:  taken = !c;
      OP_JZ:   taken = z;
      OP_JNZ:  taken = !z;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/nibbler_decode.sv
// Opcode decoder for the nibbler sequencer. Purely combinational.
// HALT (opcode F) is decoded only when NIBBLER_SEQ_HALT_EN is defined;
// otherwise F falls through to the NOP default.
import nibbler_pkg::*;

module nibbler_decode (
  input  logic [3:0] opcode,
  output dec_t       dec
);

  // Map the opcode nibble onto ALU select, B source and enable strobes
  always_comb begin
    // NOTE: assigning every field a default first keeps this block purely
    // combinational; any field left unassigned on some path would become a latch.
    dec = '0;
    case (opcode)
      OP_LIT: begin
        dec.alu_sel = ALU_PASS_B;
        dec.acc_we  = 1'b1;
        dec.flag_we = 1'b1;
      end
      OP_ADDI: begin
        dec.alu_sel = ALU_ADD;
        dec.acc_we  = 1'b1;
        dec.flag_we = 1'b1;
      end
      OP_CMPI: begin
        dec.alu_sel = ALU_SUB;
        dec.flag_we = 1'b1;
      end
      OP_NANDI: begin
        dec.alu_sel = ALU_NAND;
        dec.acc_we  = 1'b1;
        dec.flag_we = 1'b1;
      end
      OP_OUT: begin
        dec.out_we = 1'b1;
      end
      OP_IN: begin
        dec.alu_sel = ALU_PASS_B;
        dec.b_sel   = 1'b1;
        dec.acc_we  = 1'b1;
        dec.flag_we = 1'b1;
      end
      OP_JMP, OP_JC, OP_JNC, OP_JZ, OP_JNZ: begin
        dec.is_jump     = 1'b1;
        dec.is_two_byte = 1'b1;
      end
`ifdef NIBBLER_SEQ_HALT_EN
      OP_HALT: begin
        dec.is_halt = 1'b1;
      end
`endif
      default: dec = '0;
    endcase
  end

endmodule

// File: rtl/nibbler_seq.sv
// Nibbler instruction sequencer: fetches one- or two-byte instructions from
// a program ROM, drives ALU control for one EXEC cycle per instruction and
// keeps the carry/zero flags. Define NIBBLER_SEQ_HALT_EN to enable the HALT
// opcode and the HALTED state.
import nibbler_pkg::*;

module nibbler_seq #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  prog_byte,
  input  logic        prog_ready,
  output logic [11:0] pc,
  output logic [2:0]  alu_sel,
  output logic [3:0]  imm,
  output logic        b_sel,
  input  logic        alu_zero,
  input  logic        alu_cout,
  output logic        acc_we,
  output logic        out_we,
  output logic        c_flag,
  output logic        z_flag,
  output logic        halted
);

  logic [1:0] state;
  logic [3:0] opcode;
  logic [3:0] operand;
  logic [7:0] target_lo;
  logic [3:0] dec_op;
  dec_t       dec;

  // In FETCH the decoder looks at the incoming byte so the one/two-byte
  // decision is made on the same edge that latches it; elsewhere it sees
  // the latched opcode.
  assign dec_op = (state == ST_FETCH) ? prog_byte[7:4] : opcode;

  nibbler_decode u_decode (
    .opcode (dec_op),
    .dec    (dec)
  );

  // ALU control and strobes are only live during EXEC; reset forces state
  // to FETCH asynchronously, which drops all of them immediately.
  always_comb begin
    alu_sel = ALU_PASS_A;
    imm     = 4'h0;
    b_sel   = 1'b0;
    acc_we  = 1'b0;
    out_we  = 1'b0;
    if (state == ST_EXEC) begin
      alu_sel = dec.alu_sel;
      imm     = operand;
      b_sel   = dec.b_sel;
      acc_we  = dec.acc_we;
      out_we  = dec.out_we;
    end
  end

`ifdef NIBBLER_SEQ_HALT_EN
  assign halted = (state == ST_HALTED);
`else
  assign halted = 1'b0;
`endif

  // Sequencer state, program counter, instruction latches and flags
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_FETCH;
      pc        <= RESET_PC;
      opcode    <= OP_NOP;
      operand   <= 4'h0;
      target_lo <= 8'h00;
      c_flag    <= 1'b0;
      z_flag    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values (the jump test below must see the old flags).
      case (state)
        ST_FETCH: begin
          if (prog_ready) begin
            opcode  <= prog_byte[7:4];
            operand <= prog_byte[3:0];
            pc      <= pc + 12'd1;
            state   <= dec.is_two_byte ? ST_FETCH2 : ST_EXEC;
          end
        end
        ST_FETCH2: begin
          if (prog_ready) begin
            target_lo <= prog_byte;
            pc        <= pc + 12'd1;
            state     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (dec.is_jump && jump_taken(opcode, c_flag, z_flag))
            pc <= {operand, target_lo};
          if (dec.flag_we) begin
            c_flag <= alu_cout;
            z_flag <= alu_zero;
          end
          state <= dec.is_halt ? ST_HALTED : ST_FETCH;
        end
`ifdef NIBBLER_SEQ_HALT_EN
        ST_HALTED: begin
          state <= ST_HALTED;
        end
`endif
        default: begin
          state <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibbler_seq.sv
// Self-checking bench for nibbler_seq. Per-cycle stimulus and the expected
// outputs after the following rising edge are queued as a scoreboard, then
// drained against the DUT. Program ROM is a bench array addressed by pc.
module tb_nibbler_seq;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  prog_byte;
  logic        prog_ready = 1'b0;
  logic [11:0] pc;
  logic [2:0]  alu_sel;
  logic [3:0]  imm;
  logic        b_sel;
  logic        alu_zero = 1'b0;
  logic        alu_cout = 1'b0;
  logic        acc_we;
  logic        out_we;
  logic        c_flag;
  logic        z_flag;
  logic        halted;

  logic [7:0]  rom [4096];

  assign prog_byte = rom[pc];

  always #5 clock = ~clock;

  nibbler_seq dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .prog_byte  (prog_byte),
    .prog_ready (prog_ready),
    .pc         (pc),
    .alu_sel    (alu_sel),
    .imm        (imm),
    .b_sel      (b_sel),
    .alu_zero   (alu_zero),
    .alu_cout   (alu_cout),
    .acc_we     (acc_we),
    .out_we     (out_we),
    .c_flag     (c_flag),
    .z_flag     (z_flag),
    .halted     (halted)
  );

  typedef struct {
    string       tag;
    bit          rdy;
    bit          zin;
    bit          cin;
    logic [11:0] pc;
    logic [2:0]  sel;
    logic [3:0]  imm;
    logic        b;
    logic        aw;
    logic        ow;
    logic        c;
    logic        z;
    logic        h;
  } vec_t;

  vec_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic vec_t mk(input string tag, input bit rdy, input bit zin, input bit cin,
                              input logic [11:0] p, input logic [2:0] sel, input logic [3:0] im,
                              input logic b, input logic aw, input logic ow,
                              input logic c, input logic z, input logic h);
    vec_t v;
    v.tag = tag; v.rdy = rdy; v.zin = zin; v.cin = cin;
    v.pc = p; v.sel = sel; v.imm = im; v.b = b; v.aw = aw; v.ow = ow;
    v.c = c; v.z = z; v.h = h;
    return v;
  endfunction

  // Cycle ending outside EXEC: all ALU controls and strobes idle
  task automatic idle(input string tag, input bit rdy, input bit zin, input bit cin,
                      input logic [11:0] p, input logic c, input logic z);
    sb_q.push_back(mk(tag, rdy, zin, cin, p, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0, c, z, 1'b0));
  endtask

  // Cycle ending in EXEC of the expected instruction
  task automatic exe(input string tag, input logic [11:0] p, input logic [2:0] sel,
                     input logic [3:0] im, input logic b, input logic aw, input logic ow,
                     input logic c, input logic z);
    sb_q.push_back(mk(tag, 1'b1, 1'b0, 1'b0, p, sel, im, b, aw, ow, c, z, 1'b0));
  endtask

  task automatic check_outs(input vec_t v);
    check({v.tag, ".pc"},     32'(pc),      32'(v.pc));
    check({v.tag, ".sel"},    32'(alu_sel), 32'(v.sel));
    check({v.tag, ".imm"},    32'(imm),     32'(v.imm));
    check({v.tag, ".b_sel"},  32'(b_sel),   32'(v.b));
    check({v.tag, ".acc_we"}, 32'(acc_we),  32'(v.aw));
    check({v.tag, ".out_we"}, 32'(out_we),  32'(v.ow));
    check({v.tag, ".c"},      32'(c_flag),  32'(v.c));
    check({v.tag, ".z"},      32'(z_flag),  32'(v.z));
    check({v.tag, ".halted"}, 32'(halted),  32'(v.h));
  endtask

  task automatic run_sb();
    vec_t v;
    while (sb_q.size() > 0) begin
      v = sb_q.pop_front();
      prog_ready = v.rdy;
      alu_zero   = v.zin;
      alu_cout   = v.cin;
      @(posedge clock);
      #1;
      check_outs(v);
    end
  endtask

  // Assert reset mid-cycle: outputs must drop at once, hold across an edge,
  // then release before the next rising edge.
  task automatic async_reset(input string tag);
    vec_t r;
    r = mk(tag, 1'b0, 1'b0, 1'b0, 12'h000, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    check_outs(r);
    @(posedge clock);
    #1;
    check_outs(r);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    vec_t por;
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    rom[12'h000] = 8'h15; rom[12'h001] = 8'h23; rom[12'h002] = 8'h37;
    rom[12'h003] = 8'h9A; rom[12'h004] = 8'hBC;
    rom[12'hABC] = 8'hB1; rom[12'hABD] = 8'h00;
    rom[12'hABE] = 8'hC2; rom[12'hABF] = 8'h34;
    rom[12'h234] = 8'h6E; rom[12'h235] = 8'h4A; rom[12'h236] = 8'h55;
    rom[12'h237] = 8'h7D; rom[12'h238] = 8'h8F; rom[12'h239] = 8'hFF;
    rom[12'hFFF] = 8'hB3;
    rom[12'h315] = 8'h84; rom[12'h316] = 8'h56;

    // Power-on reset
    repeat (2) @(posedge clock);
    #1;
    por = mk("por", 1'b0, 1'b0, 1'b0, 12'h000, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_outs(por);
    @(negedge clock);
    reset_n = 1'b1;

    // LIT 5, ADDI 3, CMPI 7, JC 0xABC
    exe ("lit",       12'h001, 3'd2, 4'h5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle("lit_end",   1'b1, 1'b0, 1'b0, 12'h001, 1'b0, 1'b0);
    exe ("addi",      12'h002, 3'd3, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle("addi_end",  1'b1, 1'b1, 1'b0, 12'h002, 1'b0, 1'b1);
    exe ("cmpi",      12'h003, 3'd1, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle("cmpi_end",  1'b1, 1'b0, 1'b1, 12'h003, 1'b1, 1'b0);
    idle("jc_f2",     1'b1, 1'b0, 1'b0, 12'h004, 1'b1, 1'b0);
    exe ("jc_exec",   12'h005, 3'd0, 4'hA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle("jc_end",    1'b1, 1'b1, 1'b0, 12'hABC, 1'b1, 1'b0);
    // JZ not taken (z=0), then JNZ taken with a 3-cycle stall in FETCH2
    idle("jz_f2",     1'b1, 1'b0, 1'b0, 12'hABD, 1'b1, 1'b0);
    exe ("jz_exec",   12'hABE, 3'd0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle("jz_end",    1'b1, 1'b1, 1'b0, 12'hABE, 1'b1, 1'b0);
    idle("jnz_f2",    1'b1, 1'b0, 1'b0, 12'hABF, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      idle("stall",   1'b0, 1'b1, 1'b1, 12'hABF, 1'b1, 1'b0);
    exe ("jnz_exec",  12'hAC0, 3'd0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle("jnz_end",   1'b1, 1'b0, 1'b0, 12'h234, 1'b1, 1'b0);
    // IN, NANDI, OUT, opcode 7 as NOP
    exe ("in",        12'h235, 3'd2, 4'hE, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle("in_end",    1'b1, 1'b0, 1'b0, 12'h235, 1'b0, 1'b0);
    exe ("nandi",     12'h236, 3'd4, 4'hA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle("nandi_end", 1'b1, 1'b1, 1'b1, 12'h236, 1'b1, 1'b1);
    exe ("out",       12'h237, 3'd0, 4'h5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle("out_end",   1'b1, 1'b0, 1'b0, 12'h237, 1'b1, 1'b1);
    exe ("nop7",      12'h238, 3'd0, 4'hD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle("nop7_end",  1'b1, 1'b0, 1'b0, 12'h238, 1'b1, 1'b1);
    // JMP 0xFFF, then JZ at 0xFFF whose second byte comes from 0x000
    idle("jmp_f2",    1'b1, 1'b0, 1'b0, 12'h239, 1'b1, 1'b1);
    exe ("jmp_exec",  12'h23A, 3'd0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle("jmp_end",   1'b1, 1'b0, 1'b0, 12'hFFF, 1'b1, 1'b1);
    idle("wrap_f2",   1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1);
    exe ("wrap_exec", 12'h001, 3'd0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle("wrap_end",  1'b1, 1'b0, 1'b0, 12'h315, 1'b1, 1'b1);
    idle("rst_f2_in", 1'b1, 1'b0, 1'b0, 12'h316, 1'b1, 1'b1);
    run_sb();
    async_reset("rst_fetch2");

    // Restart from RESET_PC; abort a strobing EXEC with reset
    exe ("lit2",      12'h001, 3'd2, 4'h5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_sb();
    async_reset("rst_exec");
    exe ("lit3",      12'h001, 3'd2, 4'h5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle("lit3_end",  1'b1, 1'b1, 1'b0, 12'h001, 1'b0, 1'b1);
    exe ("addi3",     12'h002, 3'd3, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle("addi3_end", 1'b1, 1'b0, 1'b1, 12'h002, 1'b1, 1'b0);
    run_sb();

    // Opcode F
    rom[12'h002] = 8'hF0;
    rom[12'h003] = 8'h15;
    exe ("f_exec",    12'h003, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef NIBBLER_SEQ_HALT_EN
    for (int i = 0; i < 10; i++)
      sb_q.push_back(mk("halted", 1'b1, 1'b1, 1'b0, 12'h003, 3'd0, 4'h0,
                        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
    run_sb();
    async_reset("rst_halted");
`else
    idle("f_nop_end", 1'b1, 1'b1, 1'b0, 12'h003, 1'b1, 1'b0);
    exe ("after_f",   12'h004, 3'd2, 4'h5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    run_sb();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nibbler_seq.md
NIBBLER_SEQ -- requirements
Module: nibbler_seq

Interface
REQ-001 SHALL have parameter RESET_PC, default 12'h000: program counter value loaded on reset.
REQ-002 SHALL have port clock  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port prog_byte  in  8  program ROM byte at address pc.
REQ-005 SHALL have port prog_ready  in  1  prog_byte valid this cycle.
REQ-006 SHALL have port pc  out  12  program ROM address.
REQ-007 SHALL have port alu_sel  out  3  ALU select S: 0 pass A, 1 A-B, 2 pass B, 3 A+B, 4 NAND.
REQ-008 SHALL have port imm  out  4  immediate nibble for the ALU B operand.
REQ-009 SHALL have port b_sel  out  1  B source: 0 imm, 1 external input port.
REQ-010 SHALL have port alu_zero  in  1  ALU ZERO.
REQ-011 SHALL have port alu_cout  in  1  ALU C_out.
REQ-012 SHALL have port acc_we  out  1  accumulator load strobe, one cycle.
REQ-013 SHALL have port out_we  out  1  output-port write strobe, one cycle.
REQ-014 SHALL have ports c_flag, z_flag  out  1 each  registered flags.
REQ-015 SHALL have port halted  out  1  sequencer stopped.

Function
REQ-016 SHALL implement states FETCH, FETCH2, EXEC, HALTED.
REQ-017 FETCH: wait while prog_ready=0; on prog_ready=1 latch prog_byte as opcode[7:4]/operand[3:0], pc<=pc+1, go FETCH2 if opcode is 8..C, else EXEC.
REQ-018 FETCH2: wait while prog_ready=0; on prog_ready=1 latch target low byte, pc<=pc+1, go EXEC.
REQ-019 EXEC: one cycle, then FETCH (or HALTED, REQ-032).
REQ-020 Opcodes: 0 NOP; 1 LIT acc<=imm (sel 2); 2 ADDI (sel 3, acc_we); 3 CMPI (sel 1, flags only, no acc_we); 4 NANDI (sel 4, acc_we); 5 OUT (out_we); 6 IN (sel 2, b_sel=1, acc_we); 8 JMP; 9 JC; A JNC; B JZ; C JNZ; F HALT; 7, D, E treated as NOP.
REQ-021 alu_sel, imm, b_sel SHALL be valid throughout EXEC; alu_sel=0, b_sel=0 outside EXEC.
REQ-022 acc_we and out_we SHALL be high only during EXEC of their opcodes.
REQ-023 Opcodes 1,2,3,4,6 SHALL load c_flag<=alu_cout, z_flag<=alu_zero at the end of EXEC; all others leave flags unchanged.
REQ-024 Jump target = {operand, second byte}; taken jump loads pc<=target at end of EXEC, otherwise pc keeps its post-fetch value.
REQ-025 Jump conditions SHALL use the flag register values before EXEC.
REQ-026 pc SHALL wrap 12'hFFF -> 12'h000 on increment, including between the two bytes of a jump.
REQ-027 Latency with prog_ready held high: 2 cycles per 1-byte instruction, 3 per jump.

Reset
REQ-028 reset_n=0 SHALL immediately force pc=RESET_PC, state FETCH, c_flag=0, z_flag=0, acc_we=0, out_we=0, alu_sel=0, b_sel=0, imm=0, halted=0, regardless of clock.
REQ-029 Reset asserted in any state, including mid-jump FETCH2, SHALL abandon the instruction with no strobe emitted.
REQ-030 Release of reset_n SHALL start fetching at RESET_PC on the first subsequent rising edge.

Configuration
REQ-031 Macro NIBBLER_SEQ_HALT_EN SHALL select HALT support.
REQ-032 Defined: opcode F in EXEC enters HALTED; HALTED holds pc, flags and all strobes at 0, halted=1, exits only via reset.
REQ-033 Undefined: opcode F is NOP, HALTED state absent, halted tied 0.

Structure
REQ-034 Shared package nibbler_pkg SHALL hold the opcode constants, ALU select constants (ALU_PASS_A..ALU_NAND) and state encoding.
REQ-035 Combinational sub-module nibbler_decode SHALL map opcode to alu_sel, b_sel, acc_we/out_we/flag-update enables and is_jump/is_two_byte.

Verification
REQ-036 Reset, ROM 0x15 0x23, ready high -> EXEC1 sel=2 imm=5 acc_we=1; EXEC2 sel=3 imm=3 acc_we=1; pc=2 after 4 cycles.
REQ-037 CMPI with alu_cout=1, alu_zero=0, then 0x9A 0xBC -> acc_we=0 on CMPI, c_flag=1, pc=0xABC after jump EXEC.
REQ-038 JZ 0xB1 0x00 with z_flag=0 -> not taken, pc=prior+2, flags unchanged.
REQ-039 prog_ready low 3 cycles during FETCH2 -> state and pc held, no strobes, then jump completes normally.
REQ-040 Jump byte at 12'hFFF -> second byte fetched from 12'h000; reset_n pulse in FETCH2 -> pc=RESET_PC, no strobe.
REQ-041 0xF0 with NIBBLER_SEQ_HALT_EN -> halted=1, pc frozen 10 cycles; without macro -> NOP, next fetch proceeds.
